id_hazard_scoreboard: RTL and testbench
=======================================

Name: id_hazard_scoreboard

Overview:
- Sequencing controller for the decode stage of the 5-stage MIPS pipeline.
- Tracks destination registers of instructions in flight in EX/MEM/WB and stalls decode on read-after-write hazards against the combinational register-file read.
- Squashes wrong-path fetches after branch/jump for a fixed resolve latency.
- Drives IF/ID hold, IF/ID flush and ID/EX bubble controls.

Parameters:
- CTRL_LAT, 2, cycles of wrong-path squash after a branch/jump issues (legal 1..7).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  input  1  clock.
- RESET  input  1  synchronous active-high reset.
- id_valid  input  1  IF/ID holds a real instruction.
- id_rs_addr  input  5  decoded rs.
- id_rt_addr  input  5  decoded rt.
- id_uses_rs  input  1  instruction reads rs.
- id_uses_rt  input  1  instruction reads rt.
- id_reg_write  input  1  RegWriteD.
- id_dst_addr  input  5  final destination (rd/rt/31, already muxed).
- id_mem_to_reg  input  1  MemtoRegD (load).
- id_ctrl  input  1  BranchD or JumpD.
- hold_ifid  output  1  PC and IF/ID keep their value this cycle.
- flush_ifid  output  1  IF/ID loads NOP (32'h0) at the next edge.
- bubble_idex  output  1  ID/EX control signals forced to 0 at the next edge.
- issue  output  1  ID instruction advances into EX at the next edge.
- fwd_rs_sel  output  2  forward select for rs (FWD_EN only; else 0).
- fwd_rt_sel  output  2  forward select for rt (FWD_EN only; else 0).
- stall_count  output  CNT_W  saturating count of data-hazard stall cycles.

Interface:
- One clock CLK; reset RESET is synchronous and active-high.
- All state updates on posedge CLK.

Behaviour:
- Scoreboard: three slots EX, MEM, WB, each {valid, dst[4:0], load}. Every cycle MEM->WB and EX->MEM; WB is discarded.
- EX slot loads {1, id_dst_addr, id_mem_to_reg} when issue && id_reg_write && id_dst_addr!=0; otherwise it loads valid=0.
- Match(slot, r) = slot.valid && slot.dst==r && r!=0. Register $0 never hazards.
- Data hazard (FWD_EN undefined): (id_uses_rs && Match(any slot, rs)) || (id_uses_rt && Match(any slot, rt)). WB is included because register-file writes land after the read.
- FSM states RUN and SQUASH; 3-bit counter cnt.
- RUN:
  - stall = id_valid && data hazard.
  - hold_ifid = stall; bubble_idex = stall || !id_valid; issue = id_valid && !stall; flush_ifid = 0.
  - On issue && id_ctrl: go to SQUASH, cnt <= CTRL_LAT-1.
- SQUASH:
  - flush_ifid = 1, bubble_idex = 1, issue = 0, hold_ifid = 0.
  - Data hazards are not evaluated.
  - If cnt==0, go to RUN; else cnt <= cnt-1.
  - Total squash length is exactly CTRL_LAT cycles.
- Simultaneous events:
  - A branch with a data hazard stalls first and enters SQUASH only in the cycle it issues.
  - flush_ifid and hold_ifid are never both 1.
- stall_count increments by 1 in each RUN cycle with stall=1 and saturates at all-ones (no wrap).
- Outputs are combinational from state and inputs. With RESET high, outputs equal the idle values below.
- Reset, including mid-SQUASH or mid-stall:
  - Next edge: state=RUN, cnt=0, all slots valid=0, stall_count=0.
  - Idle outputs: hold_ifid=0, flush_ifid=0, bubble_idex=1, issue=0, fwd sels=0.

Optional Feature:
- Macro FWD_EN.
- Defined:
  - Stall only on load-use: the EX slot has load=1 and matches a used source.
  - fwd_*_sel for each used source: 1 = EX result (non-load EX match), else 2 = MEM match, else 3 = WB match, else 0. The youngest match wins.
  - A non-load EX match returns fwd_sel=1 and does not stall.
- Undefined:
  - Full-stall rule above; fwd_rs_sel and fwd_rt_sel tied to 2'b0.

Test Plan:
- Independent instructions back to back (addi $1; addi $2, both using $0) -> issue=1 every cycle, stall_count stays 0.
- add $3 writer issues, then sub $4,$3,$5 in ID (no FWD_EN) -> hold_ifid=1 for 3 cycles, bubble_idex=1 for those 3, issue on cycle 4, stall_count=3.
- Same pair with FWD_EN -> no stall, fwd_rs_sel=1 in cycle 1. Then lw $3 followed by a consumer of $3 -> exactly 1 stall cycle, then fwd_rs_sel=2.
- beq issues with CTRL_LAT=2 -> flush_ifid=1 and issue=0 for exactly 2 cycles, then RUN. A second beq in the next real slot repeats the sequence.
- RESET asserted during the second SQUASH cycle and during a RAW stall -> next cycle issue=1 for a valid ID instruction that referenced the old dst (scoreboard empty), stall_count=0.
- Writer with dst=$0 followed by a reader of $0; stall_count preset near max (force 16'hFFFE) with 3 stall cycles -> no stall for $0; counter ends at 16'hFFFF.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard
// Decode-stage sequencing controller for the 5-stage MIPS pipeline.
// It tracks the destination registers of the instructions in EX, MEM and WB.
// It stalls decode on read-after-write hazards against the combinational
// register-file read. After a branch or jump issues, it squashes wrong-path
// fetches for CTRL_LAT cycles.
//
// Build option:
//   FWD_EN  When defined, operands are forwarded and only load-use stalls.
//           fwd_rs_sel / fwd_rt_sel select the forwarding source.
//           When undefined, every in-flight RAW match stalls and the
//           forward selects are tied to zero.

module id_hazard_scoreboard #(
    parameter int CTRL_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             id_valid,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic [4:0]       id_dst_addr,
    input  logic             id_mem_to_reg,
    input  logic             id_ctrl,
    output logic             hold_ifid,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             issue,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    // The squash counter starts at CTRL_LAT-1 and runs down to zero.
    // That gives exactly CTRL_LAT squash cycles.
    localparam logic [2:0] SQUASH_INIT = 3'(CTRL_LAT - 1);

    state_t          state;
    logic [2:0]      cnt;

    // One scoreboard slot per downstream stage: {valid, dst, load}.
    logic            ex_valid;
    logic [4:0]      ex_dst;
    logic            ex_load;
    logic            mem_valid;
    logic [4:0]      mem_dst;
    logic            mem_load;
    logic            wb_valid;
    logic [4:0]      wb_dst;
    logic            wb_load;

    logic [CNT_W-1:0] stall_cnt;

    logic            rs_ex_hit;
    logic            rs_mem_hit;
    logic            rs_wb_hit;
    logic            rt_ex_hit;
    logic            rt_mem_hit;
    logic            rt_wb_hit;
    logic            data_hazard;
    logic            stall;
    logic            load_into_ex;
    logic [1:0]      rs_sel_raw;
    logic [1:0]      rt_sel_raw;

    // The load flag is only consulted for EX (and only with forwarding).
    // The remaining copies travel with their slot and are folded away here.
    logic            unused_load_bits;
    assign unused_load_bits = ^{ex_load, mem_load, wb_load};

    // A slot matches a source register only when it is valid, the
    // destinations agree, and the register is not $0.
    assign rs_ex_hit  = ex_valid  && (ex_dst  == id_rs_addr) && (id_rs_addr != 5'd0);
    assign rs_mem_hit = mem_valid && (mem_dst == id_rs_addr) && (id_rs_addr != 5'd0);
    assign rs_wb_hit  = wb_valid  && (wb_dst  == id_rs_addr) && (id_rs_addr != 5'd0);
    assign rt_ex_hit  = ex_valid  && (ex_dst  == id_rt_addr) && (id_rt_addr != 5'd0);
    assign rt_mem_hit = mem_valid && (mem_dst == id_rt_addr) && (id_rt_addr != 5'd0);
    assign rt_wb_hit  = wb_valid  && (wb_dst  == id_rt_addr) && (id_rt_addr != 5'd0);

`ifdef FWD_EN
    // Pick the youngest producer of a used source.
    // A load sitting in EX cannot forward yet, so it is skipped here
    // and stalls instead.
    function automatic logic [1:0] fwd_pick(input logic used,
                                            input logic ex_hit,
                                            input logic mem_hit,
                                            input logic wb_hit,
                                            input logic ex_is_load);
        logic [1:0] sel;
        sel = 2'd0;
        if (used) begin
            if (ex_hit && !ex_is_load) begin
                sel = 2'd1;
            end else if (mem_hit) begin
                sel = 2'd2;
            end else if (wb_hit) begin
                sel = 2'd3;
            end
        end
        return sel;
    endfunction

    assign data_hazard = (id_uses_rs && rs_ex_hit && ex_load) ||
                         (id_uses_rt && rt_ex_hit && ex_load);
    assign rs_sel_raw  = fwd_pick(id_uses_rs, rs_ex_hit, rs_mem_hit, rs_wb_hit, ex_load);
    assign rt_sel_raw  = fwd_pick(id_uses_rt, rt_ex_hit, rt_mem_hit, rt_wb_hit, ex_load);
`else
    // WB is included because its register-file write lands after the
    // decode-stage read.
    assign data_hazard = (id_uses_rs && (rs_ex_hit || rs_mem_hit || rs_wb_hit)) ||
                         (id_uses_rt && (rt_ex_hit || rt_mem_hit || rt_wb_hit));
    assign rs_sel_raw  = 2'd0;
    assign rt_sel_raw  = 2'd0;
`endif

    // Pipeline control decode from the current state and the ID instruction.
    // Reset forces the idle pattern.
    always_comb begin
        hold_ifid   = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b1;
        issue       = 1'b0;
        stall       = 1'b0;
        fwd_rs_sel  = 2'd0;
        fwd_rt_sel  = 2'd0;
        if (!RESET) begin
            if (state == SQUASH) begin
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end else begin
                stall       = id_valid && data_hazard;
                hold_ifid   = stall;
                bubble_idex = stall || !id_valid;
                issue       = id_valid && !stall;
                fwd_rs_sel  = rs_sel_raw;
                fwd_rt_sel  = rt_sel_raw;
            end
        end
    end

    assign load_into_ex = issue && id_reg_write && (id_dst_addr != 5'd0);

    // Advance the scoreboard one stage per cycle.
    // Only a real register write from an issuing instruction enters EX.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_valid  <= 1'b0;
            ex_dst    <= 5'd0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_dst   <= 5'd0;
            mem_load  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_dst    <= 5'd0;
            wb_load   <= 1'b0;
        end else begin
            wb_valid  <= mem_valid;
            wb_dst    <= mem_dst;
            wb_load   <= mem_load;
            mem_valid <= ex_valid;
            mem_dst   <= ex_dst;
            mem_load  <= ex_load;
            if (load_into_ex) begin
                ex_valid <= 1'b1;
                ex_dst   <= id_dst_addr;
                ex_load  <= id_mem_to_reg;
            end else begin
                ex_valid <= 1'b0;
                ex_dst   <= 5'd0;
                ex_load  <= 1'b0;
            end
        end
    end

    // RUN/SQUASH sequencing.
    // SQUASH is entered only when a control instruction actually issues,
    // so a branch stalled on a hazard waits in RUN first.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (issue && id_ctrl) begin
                        state <= SQUASH;
                        cnt   <= SQUASH_INIT;
                    end
                end
                SQUASH: begin
                    if (cnt == 3'd0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Count data-hazard stall cycles.
    // The count sticks at all-ones rather than wrapping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard
// Bench for id_hazard_scoreboard. It runs directed pipeline scenarios
// followed by random traffic, and compares every cycle against a
// behavioural model.
// A second instance with a 2-bit counter exercises saturation.
// Define FWD_EN for both the bench and the RTL to exercise forwarding.

module tb_id_hazard_scoreboard;

    localparam int CTRL_LAT = 2;
    localparam int CNT_W    = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_reg_write;
    logic [4:0]  id_dst_addr;
    logic        id_mem_to_reg;
    logic        id_ctrl;

    logic        hold_ifid;
    logic        flush_ifid;
    logic        bubble_idex;
    logic        issue;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic [CNT_W-1:0] stall_count;

    logic        sat_hold;
    logic        sat_flush;
    logic        sat_bubble;
    logic        sat_issue;
    logic [1:0]  sat_fwd_rs;
    logic [1:0]  sat_fwd_rt;
    logic [1:0]  sat_count;

    // Model of in-flight producers: entry 0 is the youngest (EX).
    typedef struct packed {
        logic       v;
        logic [4:0] d;
        logic       ld;
    } ent_t;

    ent_t pipe [3];
    int   squash_left;
    int   stall_total;
    int   n_checks;
    int   n_fail;

    always #5 CLK = ~CLK;

    id_hazard_scoreboard #(.CTRL_LAT(CTRL_LAT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_dst_addr(id_dst_addr),
        .id_mem_to_reg(id_mem_to_reg), .id_ctrl(id_ctrl),
        .hold_ifid(hold_ifid), .flush_ifid(flush_ifid),
        .bubble_idex(bubble_idex), .issue(issue),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .stall_count(stall_count)
    );

    id_hazard_scoreboard #(.CTRL_LAT(CTRL_LAT), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_dst_addr(id_dst_addr),
        .id_mem_to_reg(id_mem_to_reg), .id_ctrl(id_ctrl),
        .hold_ifid(sat_hold), .flush_ifid(sat_flush),
        .bubble_idex(sat_bubble), .issue(sat_issue),
        .fwd_rs_sel(sat_fwd_rs), .fwd_rt_sel(sat_fwd_rt),
        .stall_count(sat_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input int i, input logic [4:0] r);
        return pipe[i].v && (pipe[i].d == r) && (r != 5'd0);
    endfunction

    // Youngest forwardable producer: 1 = EX (non-load), 2 = MEM, 3 = WB.
    function automatic logic [1:0] modelFwd(input logic used, input logic [4:0] r);
        logic [1:0] sel;
        sel = 2'd0;
        if (used) begin
            for (int i = 2; i >= 0; i--) begin
                if (hit(i, r) && !(i == 0 && pipe[0].ld)) sel = 2'(i + 1);
            end
        end
        return sel;
    endfunction

    // Drive one cycle of ID inputs, compare all outputs against the model,
    // then advance the model across the clock edge.
    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic rw,
                                 input logic [4:0] dst, input logic ld, input logic ctrl,
                                 input logic rst);
        logic       e_hold, e_flush, e_bub, e_issue, e_stall, hz;
        logic [1:0] e_frs, e_frt;
        @(negedge CLK);
        id_valid      = v;
        id_rs_addr    = rs;
        id_rt_addr    = rt;
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        id_reg_write  = rw;
        id_dst_addr   = dst;
        id_mem_to_reg = ld;
        id_ctrl       = ctrl;
        RESET         = rst;
        #1;
        e_hold = 1'b0; e_flush = 1'b0; e_bub = 1'b1; e_issue = 1'b0; e_stall = 1'b0;
        e_frs = 2'd0; e_frt = 2'd0; hz = 1'b0;
        if (!rst) begin
            if (squash_left > 0) begin
                e_flush = 1'b1;
            end else begin
`ifdef FWD_EN
                hz = pipe[0].ld && ((urs && hit(0, rs)) || (urt && hit(0, rt)));
                e_frs = modelFwd(urs, rs);
                e_frt = modelFwd(urt, rt);
`else
                for (int i = 0; i < 3; i++) begin
                    if ((urs && hit(i, rs)) || (urt && hit(i, rt))) hz = 1'b1;
                end
`endif
                e_stall = v && hz;
                e_hold  = e_stall;
                e_bub   = e_stall || !v;
                e_issue = v && !e_stall;
            end
        end
        checkOutput("hold_ifid",   32'(hold_ifid),   32'(e_hold));
        checkOutput("flush_ifid",  32'(flush_ifid),  32'(e_flush));
        checkOutput("bubble_idex", 32'(bubble_idex), 32'(e_bub));
        checkOutput("issue",       32'(issue),       32'(e_issue));
        checkOutput("fwd_rs_sel",  32'(fwd_rs_sel),  32'(e_frs));
        checkOutput("fwd_rt_sel",  32'(fwd_rt_sel),  32'(e_frt));
        checkOutput("hold_flush_excl", 32'(hold_ifid && flush_ifid), 32'd0);
        checkOutput("stall_count", 32'(stall_count), 32'((stall_total > 65535) ? 65535 : stall_total));
        checkOutput("sat_count",   32'(sat_count),   32'((stall_total > 3) ? 3 : stall_total));
        checkOutput("sat_issue",   32'(sat_issue),   32'(e_issue));
        @(posedge CLK);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            squash_left = 0;
            stall_total = 0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (e_issue && rw && dst != 5'd0) ? '{v: 1'b1, d: dst, ld: ld} : '0;
            if (squash_left > 0) squash_left--;
            else if (e_issue && ctrl) squash_left = CTRL_LAT;
            if (e_stall) stall_total++;
        end
    endtask

    // Shorthands: ALU op writing dst, load writing dst, branch, reset cycle.
    task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst);
        applyStimulus(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, dst, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [4:0] rs, input logic [4:0] dst);
        applyStimulus(1'b1, rs, 5'd0, 1'b1, 1'b0, 1'b1, dst, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic branch(input logic [4:0] rs, input logic [4:0] rt);
        applyStimulus(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic resetCycle();
        applyStimulus(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        squash_left = 0;
        stall_total = 0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        RESET = 1'b1;
        id_valid = 1'b0; id_rs_addr = '0; id_rt_addr = '0; id_uses_rs = 1'b0;
        id_uses_rt = 1'b0; id_reg_write = 1'b0; id_dst_addr = '0;
        id_mem_to_reg = 1'b0; id_ctrl = 1'b0;

        $display("[TB] reset and idle");
        resetCycle();
        resetCycle();

        $display("[TB] independent back-to-back instructions");
        alu(5'd0, 5'd0, 5'd1);
        alu(5'd0, 5'd0, 5'd2);
        #1 checkOutput("indep_count", 32'(stall_count), 32'd0);

        $display("[TB] RAW dependence on ALU result and on a load");
        resetCycle();
        alu(5'd1, 5'd2, 5'd3);
        repeat (4) alu(5'd3, 5'd5, 5'd4);
`ifdef FWD_EN
        #1 checkOutput("raw_alu_count", 32'(stall_count), 32'd0);
`else
        #1 checkOutput("raw_alu_count", 32'(stall_count), 32'd3);
`endif
        load(5'd0, 5'd3);
        repeat (4) alu(5'd3, 5'd0, 5'd6);
`ifdef FWD_EN
        #1 checkOutput("raw_load_count", 32'(stall_count), 32'd1);
`else
        #1 checkOutput("raw_load_count", 32'(stall_count), 32'd6);
`endif

        $display("[TB] branch squash twice");
        resetCycle();
        branch(5'd1, 5'd2);
        alu(5'd8, 5'd9, 5'd10);
        alu(5'd8, 5'd9, 5'd10);
        branch(5'd1, 5'd2);
        alu(5'd8, 5'd9, 5'd10);
        alu(5'd8, 5'd9, 5'd10);
        alu(5'd8, 5'd9, 5'd10);

        $display("[TB] reset during squash and during a RAW stall");
        branch(5'd0, 5'd0);
        alu(5'd0, 5'd0, 5'd7);
        resetCycle();
        alu(5'd0, 5'd0, 5'd7);
        alu(5'd7, 5'd7, 5'd9);
        resetCycle();
        alu(5'd7, 5'd7, 5'd9);
        #1 checkOutput("post_reset_count", 32'(stall_count), 32'd0);

        $display("[TB] writes to $0 never hazard");
        alu(5'd1, 5'd1, 5'd0);
        alu(5'd0, 5'd0, 5'd11);
        #1 checkOutput("r0_count", 32'(stall_count), 32'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 99) < 85),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          5'($urandom_range(0, 3)), 1'($urandom),
                          ($urandom_range(0, 99) < 8),
                          ($urandom_range(0, 99) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
